image_loader: RTL and testbench
===============================

Name: image_loader

Overview:
- Upstream stage of the reduced-resolution image store; fills the store with one frame of 8-bit pixels.
- Accepts a valid/ready byte stream in raster order, reduced_pixels x reduced_lines pixels per frame.
- Writes each pixel into the back bank of a two-bank store.
- After the full frame is written, waits for the next vertical sync and flips the displayed bank, so no partial frame is ever shown.

Parameters:
- reduced_pixels, 19, pixels per reduced line.
- reduced_lines, 10, reduced lines per frame.
- ADDR_W, 8, per-bank address width; must satisfy 2^ADDR_W >= reduced_pixels*reduced_lines.
- VS_ACTIVE, 1, level of VSYNC during the sync pulse (1 for 800x600@60).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- START  in  1  one-cycle request to load a frame; sampled only in IDLE.
- IN_DATA  in  8  pixel byte, RRRGGGBB.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  loader accepts a byte this cycle.
- VSYNC  in  1  vertical sync from the VGA timing block, same clock domain.
- WR_EN  out  1  store write strobe.
- WR_ADDR  out  ADDR_W+1  {bank, linear pixel index}.
- WR_DATA  out  8  store write data.
- DISP_BANK  out  1  bank the image store reads for display.
- BUSY  out  1  high from START accept until the bank flip.
- DONE  out  1  one-cycle pulse on the bank flip.

Behaviour:
- Reset (async, RESET_N=0): state IDLE; IN_READY=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, DISP_BANK=0, BUSY=0, DONE=0; x, y and index counters at 0; VSYNC delay register at ~VS_ACTIVE.
- Reset mid-load: the partially written bank stays hidden because DISP_BANK returns to 0. Nothing resumes; the next load needs a new START.
- All outputs are registered.
- FSM states: IDLE, LOAD, WAIT_VS.
- IDLE: IN_READY=0. START=1 -> LOAD next edge; counters cleared; BUSY=1; IN_READY=1 from the first LOAD cycle.
- START outside IDLE: ignored; no restart, no error.
- Transfer: IN_VALID & IN_READY at a rising edge.
  - Next cycle: WR_EN=1, WR_ADDR={~DISP_BANK, idx}, WR_DATA=IN_DATA. Latency exactly 1 cycle.
  - WR_EN=0 in every cycle not following a transfer.
  - IN_VALID without IN_READY has no effect; no byte is dropped or duplicated.
- Counters:
  - Per transfer: idx+1; x+1, wrapping from reduced_pixels-1 to 0 with y+1.
  - idx is a running counter; no multiplier.
  - Width rule: idx never exceeds reduced_pixels*reduced_lines-1.
- Last pixel (x=reduced_pixels-1, y=reduced_lines-1): IN_READY=0 from the same edge. Next state WAIT_VS; the final WR_EN still occurs one cycle later.
- WAIT_VS: IN_READY=0.
  - Sync edge = VSYNC==VS_ACTIVE while the registered VSYNC != VS_ACTIVE.
  - On the first sync edge seen in WAIT_VS: DISP_BANK toggles; DONE=1 for one cycle; BUSY=0; next state IDLE.
  - Sync edges in IDLE or LOAD are ignored.
  - An edge in the same cycle as the last transfer does not count; the loader waits for the next one.
  - The final write always precedes the flip.
- START asserted in the DONE cycle (state already IDLE next): accepted on the following edge as a normal IDLE request.
- Back-to-back frames alternate banks: frame 1 writes bank 1, frame 2 writes bank 0, and so on.

Decomposition:
- Shared package (vga_pkg): reduced_pixels/reduced_lines defaults, ADDR_W, FSM state encoding, and the colour format constant. The image store reuses these.
- One sub-module, vsync_edge: VSYNC register and active-edge detect with VS_ACTIVE polarity. It is also reusable by the image store for frame-start alignment.

Test Plan:
- Reset: assert RESET_N=0 mid-LOAD after 50 pixels -> all outputs 0 within the reset cycle, DISP_BANK=0, IN_READY stays 0 after release until START.
- Full frame, continuous IN_VALID, IN_DATA=idx[7:0]:
  - writes land at WR_ADDR=256+0 .. 256+189 with WR_DATA=0..189, each one cycle after its transfer;
  - exactly 190 WR_EN pulses; IN_READY low after the 190th transfer.
- Flip timing: VSYNC pulse 20 cycles after the last write -> DISP_BANK 0->1 and a DONE pulse on the edge cycle +1. A VSYNC pulse during LOAD causes no flip.
- Backpressure: IN_VALID toggling 1,0,0,1 randomly -> WR_DATA sequence is identical to the sent sequence, with no gaps in idx.
- Ignored inputs: START pulses during LOAD and WAIT_VS -> counters are unaffected and BUSY stays 1.
- Second frame:
  - START after DONE -> writes target bank 0 (WR_ADDR MSB=0);
  - after the next VSYNC, DISP_BANK=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the reduced-resolution image path (loader and store).
package vga_pkg;
  localparam int DEF_REDUCED_PIXELS = 19;
  localparam int DEF_REDUCED_LINES  = 10;
  // 2^DEF_ADDR_W must cover DEF_REDUCED_PIXELS * DEF_REDUCED_LINES pixels
  localparam int DEF_ADDR_W         = 8;
  // VSYNC level during the sync pulse for 800x600@60
  localparam logic DEF_VS_ACTIVE    = 1'b1;

  // Pixel colour format RRRGGGBB
  localparam int PIXEL_W = 8;
  localparam int R_BITS  = 3;
  localparam int G_BITS  = 3;
  localparam int B_BITS  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_VS = 2'd2
  } load_state_t;
endpackage

// File: rtl/image_loader_if.sv
// Pixel stream in and store write bus out of the image loader.
// Handshake: a byte moves on a rising edge where IN_VALID and IN_READY are
// both 1; IN_VALID alone never moves data, and IN_DATA must hold while
// IN_VALID is high and IN_READY low. WR_EN is a one-cycle write strobe.
interface image_loader_if #(
  parameter int ADDR_W = vga_pkg::DEF_ADDR_W
);
  logic [7:0]      IN_DATA;
  logic            IN_VALID;
  logic            IN_READY;
  logic            WR_EN;
  logic [ADDR_W:0] WR_ADDR;
  logic [7:0]      WR_DATA;

  // Loader side
  modport slave (
    input  IN_DATA, IN_VALID,
    output IN_READY, WR_EN, WR_ADDR, WR_DATA
  );

  // Source / store side
  modport master (
    output IN_DATA, IN_VALID,
    input  IN_READY, WR_EN, WR_ADDR, WR_DATA
  );
endinterface

// File: rtl/image_loader_vsync_edge.sv
// VSYNC register plus active-edge detect; polarity set by VS_ACTIVE.
module vsync_edge #(
  parameter logic VS_ACTIVE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic sync_edge
);
  logic vs_q;
  logic vs_d;

  // Next value of the delayed VSYNC is simply the current input
  always_comb begin
    vs_d = vsync;
  end

  // Delay register starts inactive so a sync already active at reset
  // release is reported as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_q <= ~VS_ACTIVE;
    else        vs_q <= vs_d;
  end

  assign sync_edge = (vsync == VS_ACTIVE) && (vs_q != VS_ACTIVE);
endmodule

// File: rtl/image_loader.sv
// Fills the back bank of a two-bank image store with one frame from a
// valid/ready byte stream, then flips the displayed bank on the next VSYNC.
module image_loader
  import vga_pkg::*;
#(
  parameter int   reduced_pixels = DEF_REDUCED_PIXELS,
  parameter int   reduced_lines  = DEF_REDUCED_LINES,
  parameter int   ADDR_W         = DEF_ADDR_W,
  parameter logic VS_ACTIVE      = DEF_VS_ACTIVE
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                START,
  input  logic                VSYNC,
  image_loader_if.slave       bus,
  output logic                DISP_BANK,
  output logic                BUSY,
  output logic                DONE,
  output load_state_t         DBG_STATE
);
  localparam int X_W = (reduced_pixels > 1) ? $clog2(reduced_pixels) : 1;
  localparam int Y_W = (reduced_lines  > 1) ? $clog2(reduced_lines)  : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(reduced_pixels - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(reduced_lines - 1);

  load_state_t     state_q, state_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic            in_ready_q, in_ready_d;
  logic            wr_en_q, wr_en_d;
  logic [ADDR_W:0] wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            disp_bank_q, disp_bank_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sync_edge;
  logic            last_px;

  vsync_edge #(.VS_ACTIVE(VS_ACTIVE)) u_vsync_edge (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .vsync     (VSYNC),
    .sync_edge (sync_edge)
  );

  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);

  // Next-state, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    disp_bank_d = disp_bank_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b0;
        if (START) begin
          state_d    = ST_LOAD;
          x_d        = '0;
          y_d        = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (bus.IN_VALID && in_ready_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {~disp_bank_q, idx_q};
          wr_data_d = bus.IN_DATA;
          if (last_px) begin
            // Counters hold at the last pixel so idx never passes the frame size
            in_ready_d = 1'b0;
            state_d    = ST_WAIT_VS;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + Y_W'(1);
            end else begin
              x_d = x_q + X_W'(1);
            end
          end
        end
      end
      ST_WAIT_VS: begin
        // The final write strobe is already registered before any flip here
        in_ready_d = 1'b0;
        if (sync_edge) begin
          disp_bank_d = ~disp_bank_q;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      disp_bank_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      disp_bank_q <= disp_bank_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.IN_READY = in_ready_q;
  assign bus.WR_EN    = wr_en_q;
  assign bus.WR_ADDR  = wr_addr_q;
  assign bus.WR_DATA  = wr_data_q;
  assign DISP_BANK    = disp_bank_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign DBG_STATE    = state_q;
endmodule

// File: tb/tb_image_loader.sv
// Directed-plus-random bench for image_loader with a frame-level reference model.
module tb_image_loader;
  import vga_pkg::*;

  localparam int NPIX = 19 * 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        vsync = 1'b0;
  logic        disp_bank;
  logic        busy;
  logic        done;
  load_state_t dbg_state;

  image_loader_if #(.ADDR_W(8)) bus ();

  image_loader dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .START     (start),
    .VSYNC     (vsync),
    .bus       (bus),
    .DISP_BANK (disp_bank),
    .BUSY      (busy),
    .DONE      (done),
    .DBG_STATE (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: loader phase, pixels taken this frame, expected outputs
  logic [16:0] exp_q[$];
  int   phase;      // 0 idle, 1 taking pixels, 2 awaiting sync
  int   count;
  int   wr_seen;
  logic exp_ready, exp_wr_en, exp_bank, exp_busy, exp_done, prev_vs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase     = 0;
    count     = 0;
    exp_ready = 1'b0;
    exp_wr_en = 1'b0;
    exp_bank  = 1'b0;
    exp_busy  = 1'b0;
    exp_done  = 1'b0;
    prev_vs   = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.IN_READY, 0);
    chk({tag, "_wr_en"},    bus.WR_EN, 0);
    chk({tag, "_wr_addr"},  bus.WR_ADDR, 0);
    chk({tag, "_wr_data"},  bus.WR_DATA, 0);
    chk({tag, "_disp_bank"}, disp_bank, 0);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_done"},     done, 0);
    chk({tag, "_state"},    dbg_state, ST_IDLE);
  endtask

  // One clock: check outputs now visible, advance model with current inputs
  task automatic tick();
    logic        xfer;
    logic        vs_edge;
    logic [16:0] e;
    chk("in_ready", bus.IN_READY, exp_ready);
    chk("wr_en", bus.WR_EN, exp_wr_en);
    if (bus.WR_EN === 1'b1) begin
      wr_seen++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL wr_extra observed=write expected=no_write");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", bus.WR_ADDR, e[16:8]);
        chk("wr_data", bus.WR_DATA, e[7:0]);
      end
    end
    chk("disp_bank", disp_bank, exp_bank);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);

    xfer    = exp_ready && bus.IN_VALID;
    vs_edge = vsync && !prev_vs;
    prev_vs = vsync;
    exp_wr_en = xfer;
    exp_done  = 1'b0;
    if (xfer) begin
      exp_q.push_back({~exp_bank, count[7:0], bus.IN_DATA});
      count++;
    end
    case (phase)
      0: if (start) begin
        phase = 1; count = 0; exp_busy = 1'b1; exp_ready = 1'b1;
      end
      1: if (count == NPIX) begin
        phase = 2; exp_ready = 1'b0;
      end
      2: if (vs_edge) begin
        exp_bank = ~exp_bank; exp_done = 1'b1; exp_busy = 1'b0; phase = 0;
      end
      default: phase = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = 8'h00;
    model_reset();
    wr_seen = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Idle: valid data without START is not accepted
    for (int i = 0; i < 4; i++) begin
      bus.IN_VALID = 1'($urandom_range(0, 1));
      bus.IN_DATA  = 8'($urandom);
      tick();
    end

    // Aborted frame: reset after 50 pixels
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (count < 50 && guard < 200) begin
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 8'($urandom);
      tick();
      guard++;
    end
    chk("abort_timeout", guard < 200, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.IN_VALID = 1'b1;
    repeat (5) tick();

    // Frame 1: continuous stream, data = pixel index, stray START and VSYNC
    wr_seen = 0;
    start = 1'b1;
    bus.IN_DATA = 8'h00;
    tick();
    start = 1'b0;
    guard = 0;
    while (phase != 2 && guard < 400) begin
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = count[7:0];
      start        = (count == 60);
      vsync        = (count >= 100 && count < 103);
      tick();
      guard++;
    end
    chk("f1_timeout", guard < 400, 1);
    bus.IN_VALID = 1'b0;
    start = 1'b0;
    vsync = 1'b0;
    tick();
    chk("f1_write_count", wr_seen, NPIX);
    for (int i = 0; i < 19; i++) begin
      start = (i == 7);
      tick();
    end
    start = 1'b0;
    vsync = 1'b1;
    guard = 0;
    while (phase != 0 && guard < 10) begin
      tick();
      guard++;
    end
    chk("f1_flip_timeout", guard < 10, 1);

    // Frame 2: START in the DONE cycle, random backpressure, sync on last pixel
    start = 1'b1;
    vsync = 1'b0;
    tick();
    start = 1'b0;
    wr_seen = 0;
    guard = 0;
    while (phase == 1 && guard < 2000) begin
      bus.IN_VALID = 1'($urandom_range(0, 1));
      bus.IN_DATA  = 8'($urandom);
      vsync        = (count == NPIX - 1) && bus.IN_VALID;
      tick();
      guard++;
    end
    chk("f2_timeout", guard < 2000, 1);
    bus.IN_VALID = 1'b0;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (5) tick();
    chk("f2_no_early_flip", disp_bank, 1);
    chk("f2_write_count", wr_seen, NPIX);
    vsync = 1'b1;
    guard = 0;
    while (phase != 0 && guard < 10) begin
      tick();
      guard++;
    end
    chk("f2_flip_timeout", guard < 10, 1);
    vsync = 1'b0;
    repeat (3) tick();
    chk("f2_final_bank", disp_bank, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
